// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the ALU command issuer.
// Latency: none (package only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W_DEF = 40;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO holding packed {op,a,b} commands, first-word fall-through head.
// Latency: a push is visible at pop_dat the cycle after the write edge.
// Backpressure: full blocks push, empty blocks pop; both are ignored when illegal.
module alu_cmd_fifo #(
    parameter int WIDTH = 85,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues {op,a,b} commands and drives them one at a time through the registered ALU; optional counters under ALU_CMD_ISSUER_STATS_EN.
// Latency: legal head in IDLE -> res_valid 3 cycles later; rejected head -> 1 cycle later.
// Backpressure: cmd_ready = !fifo_full; result held stable until res_valid && res_ready.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_s,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
`ifdef ALU_CMD_ISSUER_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_rejected
`endif
);

    localparam int CMD_W = 5 + 2 * DATA_W;

    logic [CMD_W-1:0]  head;
    logic [4:0]        head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    state_t            state;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign {head_op, head_a, head_b} = head;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({cmd_op, cmd_a, cmd_b}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= OP_NOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Rejected commands never touch the ALU bus.
                    if (!fifo_empty) begin
                        if (!is_legal_op(head_op)) begin
                            res_err   <= 1'b1;
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if ((head_op == OP_DIV) && (head_b == '0)) begin
                            res_err   <= 1'b1;
                            res_data  <= '1;
                            res_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            alu_a <= head_a;
                            alu_b <= head_b;
                            alu_s <= head_op;
                            state <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    alu_s     <= OP_NOP;
                    res_data  <= alu_out;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CMD_ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued   <= '0;
            stat_rejected <= '0;
        end else if (res_valid && res_ready) begin
            if (res_err) begin
                stat_rejected <= stat_rejected + 32'd1;
            end else begin
                stat_issued <= stat_issued + 32'd1;
            end
        end
    end
`endif

endmodule
